histo_deserializer: RTL and testbench

HISTO_DESERIALIZER -- requirements
Module: histo_deserializer

---
 rtl/histo_deserializer.sv | 207 ++++++++++++++++++++
 tb/tb_histo_deserializer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/histo_deserializer.sv
// ---------------------------------------------------------------------------
// histo_deserializer
//
// Purpose:
//   Receives a serial histogram stream, one bit per clock. Each word has a
//   low start bit, DATA_WIDTH data bits (MSB first), an optional even-parity
//   bit and a high stop bit. Accepted words are presented with their bin
//   index. The bin index counts up through a frame of NUM_BINS words and
//   then wraps to 0.
//
// Configuration macro:
//   HISTO_RX_PARITY_EN - when defined, every word carries an even-parity bit
//                        after the data, and parity_error can pulse. When it
//                        is undefined, there is no parity bit and
//                        parity_error is tied low.
//
// Ports:
//   clk            in   single clock; serial_in is sampled on each rising edge
//   rst_n          in   asynchronous active-low reset
//   serial_in      in   serial stream, idles high
//   bin_clear      in   synchronous resync: bin index to 0, drops partial word
//   data_out       out  [DATA_WIDTH] last accepted bin count
//   bin_out        out  [BIN_WIDTH]  bin index belonging to data_out
//   data_valid     out  one-cycle pulse when data_out/bin_out update
//   frame_done     out  one-cycle pulse with data_valid of the last bin
//   framing_error  out  one-cycle pulse when the stop bit is low
//   parity_error   out  one-cycle pulse on an even-parity mismatch
// ---------------------------------------------------------------------------
module histo_deserializer #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_BINS   = 1024,
    parameter int BIN_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_in,
    input  logic                  bin_clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [BIN_WIDTH-1:0]  bin_out,
    output logic                  data_valid,
    output logic                  frame_done,
    output logic                  framing_error,
    output logic                  parity_error
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [BIN_WIDTH-1:0] LAST_BIN = BIN_WIDTH'(NUM_BINS - 1);

`ifdef HISTO_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;
`endif

    state_t                  state;
    state_t                  state_next;
    logic [CNT_WIDTH-1:0]    bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [BIN_WIDTH-1:0]    bin_idx;
    logic                    accept;
    logic                    frame_err_next;
`ifdef HISTO_RX_PARITY_EN
    logic                    par_bad;
    logic                    par_err_next;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the per-word decision made in the STOP cycle.
    // bin_clear overrides everything, so a word caught in STOP is dropped
    // silently instead of producing data_valid or an error pulse.
    always_comb begin
        state_next     = state;
        accept         = 1'b0;
        frame_err_next = 1'b0;
`ifdef HISTO_RX_PARITY_EN
        par_err_next   = 1'b0;
`endif
        if (bin_clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!serial_in) begin
                        state_next = DATA;
                    end
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef HISTO_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
`ifdef HISTO_RX_PARITY_EN
                PARITY: begin
                    state_next = STOP;
                end
`endif
                STOP: begin
                    if (serial_in) begin
                        state_next = IDLE;
`ifdef HISTO_RX_PARITY_EN
                        if (par_bad) begin
                            par_err_next = 1'b1;
                        end else begin
                            accept = 1'b1;
                        end
`else
                        accept = 1'b1;
`endif
                    end else begin
                        // A low stop bit means the line may be stuck low, so
                        // wait for it to return high before hunting for a start.
                        frame_err_next = 1'b1;
                        state_next     = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (serial_in) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Datapath: shift register, bit counter, bin index and registered
    // output pulses. Outputs are registered, so data_valid shows up in the
    // cycle right after the edge that samples the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt       <= '0;
            shift_reg     <= '0;
            bin_idx       <= '0;
            data_out      <= '0;
            bin_out       <= '0;
            data_valid    <= 1'b0;
            frame_done    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            data_valid    <= accept;
            frame_done    <= accept && (bin_idx == LAST_BIN);
            framing_error <= frame_err_next;
            if (bin_clear) begin
                bin_idx <= '0;
                bit_cnt <= '0;
            end else begin
                if (state == IDLE) begin
                    bit_cnt <= '0;
                end
                if (state == DATA) begin
                    shift_reg <= {shift_reg[DATA_WIDTH-2:0], serial_in};
                    bit_cnt   <= bit_cnt + CNT_WIDTH'(1);
                end
                if (accept) begin
                    data_out <= shift_reg;
                    bin_out  <= bin_idx;
                    bin_idx  <= (bin_idx == LAST_BIN) ? '0 : bin_idx + BIN_WIDTH'(1);
                end
            end
        end
    end

`ifdef HISTO_RX_PARITY_EN
    // Even parity: data bits plus the parity bit must hold an even number
    // of ones, so any odd XOR over them is a mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            parity_error <= par_err_next;
            if (state == PARITY) begin
                par_bad <= (^shift_reg) ^ serial_in;
            end
        end
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_histo_deserializer.sv
// ---------------------------------------------------------------------------
// tb_histo_deserializer
//
// Testbench for histo_deserializer with the default parameters. It sends
// directed and random words. A reference model records the expected bin
// index for each accepted word and counts expected error pulses. A monitor
// takes expected results from a queue whenever data_valid pulses.
// ---------------------------------------------------------------------------
module tb_histo_deserializer;

    localparam int DW = 24;
    localparam int NB = 1024;
    localparam int BW = 10;
`ifdef HISTO_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int WORD_CYCLES = DW + 2 + (PAR_EN ? 1 : 0);

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          serial_in = 1'b1;
    logic          bin_clear = 1'b0;
    logic [DW-1:0] data_out;
    logic [BW-1:0] bin_out;
    logic          data_valid;
    logic          frame_done;
    logic          framing_error;
    logic          parity_error;

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] bin;
        bit            fd;
    } exp_t;

    exp_t          exp_q[$];
    int            checks    = 0;
    int            failures  = 0;
    int            model_bin = 0;
    int            exp_frame = 0;
    int            obs_frame = 0;
    int            exp_par   = 0;
    int            obs_par   = 0;
    int            cyc       = 0;
    int            last_valid_cyc = -1;
    bit            mon_en    = 1'b0;
    logic [DW-1:0] last_data = '0;
    logic [BW-1:0] last_bin  = '0;

    histo_deserializer #(
        .DATA_WIDTH(DW),
        .NUM_BINS  (NB),
        .BIN_WIDTH (BW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_in    (serial_in),
        .bin_clear    (bin_clear),
        .data_out     (data_out),
        .bin_out      (bin_out),
        .data_valid   (data_valid),
        .frame_done   (frame_done),
        .framing_error(framing_error),
        .parity_error (parity_error)
    );

    always #5 clk = ~clk;

    // Counts rising edges so that latency can be measured in cycles.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Hold the line high (idle) for n cycles.
    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic clearBins();
        serial_in = 1'b1;
        bin_clear = 1'b1;
        @(negedge clk);
        bin_clear = 1'b0;
        model_bin = 0;
    endtask

    // Send one word and update the reference model with what should happen:
    // an accepted word is queued with its bin, while errors and drops only
    // change the model counters.
    task automatic applyStimulus(input logic [DW-1:0] value, input bit stop_bit,
                                 input bit par_flip, input bit clear_at_stop,
                                 output int start_cyc);
        exp_t e;
        bit   p;
        p = (^value) ^ par_flip;
        if (clear_at_stop) begin
            model_bin = 0;
        end else if (!stop_bit) begin
            exp_frame++;
        end else if (PAR_EN && par_flip) begin
            exp_par++;
        end else begin
            e.data = value;
            e.bin  = BW'(model_bin);
            e.fd   = (model_bin == NB - 1);
            exp_q.push_back(e);
            model_bin = (model_bin + 1) % NB;
        end
        start_cyc = cyc;
        serial_in = 1'b0;
        @(negedge clk);
        for (int i = DW - 1; i >= 0; i--) begin
            serial_in = value[i];
            @(negedge clk);
        end
        if (PAR_EN) begin
            serial_in = p;
            @(negedge clk);
        end
        serial_in = stop_bit;
        bin_clear = clear_at_stop;
        @(negedge clk);
        bin_clear = 1'b0;
        serial_in = 1'b1;
    endtask

    // Monitor: compares every data_valid against the scoreboard queue. It also
    // checks that outputs hold steady when errors or bin_clear occur.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (data_valid) begin
                last_valid_cyc = cyc;
                checkOutput("valid_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("data_out", 64'(data_out), 64'(e.data));
                    checkOutput("bin_out", 64'(bin_out), 64'(e.bin));
                    checkOutput("frame_done", 64'(frame_done), 64'(e.fd));
                    last_data = e.data;
                    last_bin  = e.bin;
                end
            end else begin
                if (frame_done) begin
                    checkOutput("frame_done_without_valid", 64'(frame_done), 64'(data_valid));
                end
                if (framing_error || parity_error || bin_clear) begin
                    checkOutput("data_out_hold", 64'(data_out), 64'(last_data));
                    checkOutput("bin_out_hold", 64'(bin_out), 64'(last_bin));
                end
            end
            if (framing_error) obs_frame++;
            if (parity_error)  obs_par++;
        end
    end

    initial begin
        int            s;
        logic [DW-1:0] v;
        bit            stop_b;
        bit            pf;
        bit            clr;
        int            gap;

        // Reset state
        rst_n     = 1'b0;
        serial_in = 1'b1;
        bin_clear = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_data_out", 64'(data_out), 64'(0));
        checkOutput("reset_bin_out", 64'(bin_out), 64'(0));
        checkOutput("reset_data_valid", 64'(data_valid), 64'(0));
        checkOutput("reset_frame_done", 64'(frame_done), 64'(0));
        checkOutput("reset_framing_error", 64'(framing_error), 64'(0));
        checkOutput("reset_parity_error", 64'(parity_error), 64'(0));
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Single word and its latency
        applyStimulus(24'hABCDEF, 1'b1, 1'b0, 1'b0, s);
        idle(3);
        checkOutput("latency", 64'(last_valid_cyc - s), 64'(WORD_CYCLES));

        // Full frame back-to-back, then one word past the wrap
        clearBins();
        for (int i = 0; i < NB; i++) begin
            applyStimulus(DW'(i), 1'b1, 1'b0, 1'b0, s);
        end
        applyStimulus(24'h5A5A5A, 1'b1, 1'b0, 1'b0, s);
        idle(2);

        // Low stop bit, line stuck low, then a good word
        clearBins();
        applyStimulus(24'h000001, 1'b0, 1'b0, 1'b0, s);
        serial_in = 1'b0;
        repeat (5) @(negedge clk);
        idle(1);
        applyStimulus(24'h000002, 1'b1, 1'b0, 1'b0, s);
        idle(2);
        checkOutput("framing_error_count", 64'(obs_frame), 64'(exp_frame));

        // bin_clear during the STOP cycle of bin 5
        clearBins();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(DW'($urandom), 1'b1, 1'b0, 1'b0, s);
        end
        applyStimulus(24'h0000AA, 1'b1, 1'b0, 1'b1, s);
        applyStimulus(24'h0000BB, 1'b1, 1'b0, 1'b0, s);
        idle(2);

        // Reset while data bit 12 is on the line
        serial_in = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            serial_in = 1'($urandom);
            @(negedge clk);
        end
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkOutput("midreset_data_out", 64'(data_out), 64'(0));
        checkOutput("midreset_bin_out", 64'(bin_out), 64'(0));
        checkOutput("midreset_data_valid", 64'(data_valid), 64'(0));
        checkOutput("midreset_frame_done", 64'(frame_done), 64'(0));
        checkOutput("midreset_framing_error", 64'(framing_error), 64'(0));
        checkOutput("midreset_parity_error", 64'(parity_error), 64'(0));
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        model_bin = 0;
        last_data = '0;
        last_bin  = '0;
        mon_en    = 1'b1;
        idle(1);
        applyStimulus(24'h123456, 1'b1, 1'b0, 1'b0, s);
        idle(2);

`ifdef HISTO_RX_PARITY_EN
        // Wrong parity bit, then a correct word
        clearBins();
        applyStimulus(24'h000003, 1'b1, 1'b1, 1'b0, s);
        applyStimulus(24'h000004, 1'b1, 1'b0, 1'b0, s);
        idle(2);
        checkOutput("parity_error_count", 64'(obs_par), 64'(exp_par));
`endif

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            v      = DW'($urandom);
            stop_b = ($urandom_range(0, 9) != 0);
            pf     = PAR_EN && ($urandom_range(0, 9) == 0);
            clr    = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 19) == 0) clearBins();
            applyStimulus(v, stop_b, pf, clr, s);
            gap = $urandom_range(0, 2);
            if (!stop_b && !clr && gap == 0) gap = 1;
            idle(gap);
        end

        // Drain and final tallies
        idle(5);
        checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));
        checkOutput("framing_error_total", 64'(obs_frame), 64'(exp_frame));
        checkOutput("parity_error_total", 64'(obs_par), 64'(exp_par));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
